// File: rtl/bus_fabric_n.sv
// Single-master, N-slave bus fabric with per-slave base/mask decode,
// per-access watchdog, error response and fault logging.
module bus_fabric_n #(
    parameter int NUM_SLAVES = 8,
    parameter int ADR_W      = 32,
    parameter int DAT_W      = 32,
    parameter int TIMEOUT    = 255,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLV_MASK = '1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        m_stb_i,
    input  logic                        m_we_i,
    input  logic [ADR_W-1:0]            m_adr_i,
    input  logic [DAT_W-1:0]            m_dat_i,
    output logic [DAT_W-1:0]            m_dat_o,
    output logic                        m_ack_o,
    output logic                        m_err_o,
    output logic [NUM_SLAVES-1:0]       s_cs_o,
    output logic                        s_we_o,
    output logic [ADR_W-1:0]            s_adr_o,
    output logic [DAT_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    output logic [ADR_W-1:0]            err_adr_o,
    output logic [7:0]                  err_cnt_o,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        RESP_OK  = 2'd2,
        RESP_ERR = 2'd3
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t                  state;
    logic [15:0]             wd;
    logic                    hit;
    logic [NUM_SLAVES-1:0]   hit_oh;
    logic                    sel_ack;
    logic [DAT_W-1:0]        sel_dat;

    // Address decode: scan from the top so the lowest hitting slave wins.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & SLV_MASK[i*ADR_W +: ADR_W]) ==
                (SLV_BASE[i*ADR_W +: ADR_W] & SLV_MASK[i*ADR_W +: ADR_W])) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // Pick ack/data of the selected slave only; others are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_cs_o[i]) begin
                sel_ack = s_ack_i[i];
                sel_dat = s_dat_i[i*DAT_W +: DAT_W];
            end
        end
    end

    // Access FSM with registered bus outputs, watchdog and fault log.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            wd        <= '0;
            s_cs_o    <= '0;
            s_we_o    <= 1'b0;
            s_adr_o   <= '0;
            s_dat_o   <= '0;
            m_dat_o   <= '0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            err_adr_o <= '0;
            err_cnt_o <= '0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m_stb_i) begin
                        s_adr_o <= m_adr_i;
                        s_we_o  <= m_we_i;
                        s_dat_o <= m_dat_i;
                        if (hit) begin
                            s_cs_o <= hit_oh;
                            wd     <= '0;
                            state  <= ACTIVE;
                        end else begin
                            m_err_o <= 1'b1;
                            state   <= RESP_ERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (sel_ack) begin
                        if (!s_we_o) begin
                            m_dat_o <= sel_dat;
                        end
                        s_cs_o  <= '0;
                        m_ack_o <= 1'b1;
                        state   <= RESP_OK;
                    end else if (wd == WD_LAST) begin
                        s_cs_o  <= '0;
                        m_err_o <= 1'b1;
                        state   <= RESP_ERR;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                RESP_OK: begin
                    state <= IDLE;
                end
                RESP_ERR: begin
                    err_adr_o <= s_adr_o;
                    if (err_cnt_o != 8'hFF) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_bus_fabric_n.sv
// Bench for bus_fabric_n: directed scenarios plus random accesses
// checked against a transaction-level model of the fabric.
module tb_bus_fabric_n;

    localparam int N  = 8;
    localparam int TO = 4;

    localparam logic [N*32-1:0] BASE = {
        32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
        32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASK = {
        32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000,
        32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic [31:0] base_tab [N] = '{32'h0000_0000, 32'h1000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h4000_0000, 32'h5000_0000,
        32'h6000_0000, 32'h7000_0000};
    logic [31:0] mask_tab [N] = '{32'hF000_0000, 32'hF000_0000,
        32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFFFF_0000,
        32'hF000_0000, 32'hF000_0000};

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m_stb_i;
    logic          m_we_i;
    logic [31:0]   m_adr_i;
    logic [31:0]   m_dat_i;
    logic [31:0]   m_dat_o;
    logic          m_ack_o;
    logic          m_err_o;
    logic [N-1:0]  s_cs_o;
    logic          s_we_o;
    logic [31:0]   s_adr_o;
    logic [31:0]   s_dat_o;
    logic [N*32-1:0] s_dat_i;
    logic [N-1:0]  s_ack_i;
    logic [31:0]   err_adr_o;
    logic [7:0]    err_cnt_o;
    logic          busy_o;

    logic [31:0] slv_dat [N];
    logic [31:0] exp_mdat;
    logic [31:0] exp_eadr;
    int          exp_ecnt;
    int          n_pass;
    int          n_total;

    always #5 clk = ~clk;

    bus_fabric_n #(
        .NUM_SLAVES(N),
        .ADR_W(32),
        .DAT_W(32),
        .TIMEOUT(TO),
        .SLV_BASE(BASE),
        .SLV_MASK(MASK)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .m_stb_i(m_stb_i),
        .m_we_i(m_we_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .s_cs_o(s_cs_o),
        .s_we_o(s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),
        .err_adr_o(err_adr_o),
        .err_cnt_o(err_cnt_o),
        .busy_o(busy_o)
    );

    function automatic int ref_slave(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & mask_tab[i]) == (base_tab[i] & mask_tab[i])) return i;
        end
        return -1;
    endfunction

    task automatic load_slv_data();
        for (int i = 0; i < N; i++) begin
            slv_dat[i] = $urandom;
            s_dat_i[i*32 +: 32] = slv_dat[i];
        end
    endtask

    // One master access starting at a negedge; ends at a negedge in IDLE.
    // w = slave wait states before its ack (w >= TO means it never acks).
    task automatic access(input logic [31:0] adr, input logic we,
                          input logic [31:0] dat, input int w,
                          input string tag);
        int sel;
        int a;
        int rk;
        bit ok;
        logic [N-1:0] ecs;
        sel = ref_slave(adr);
        load_slv_data();
        if (sel < 0) begin
            a = 0; ok = 1'b0;
        end else if (w < TO) begin
            a = w + 1; ok = 1'b1;
        end else begin
            a = TO; ok = 1'b0;
        end
        rk = a + 1;
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_adr_i = adr;
        m_dat_i = dat;
        s_ack_i = N'($urandom);
        for (int k = 1; k <= rk + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == rk && ok && !we) exp_mdat = slv_dat[sel];
            if (k == rk + 1 && !ok) begin
                exp_eadr = adr;
                if (exp_ecnt < 255) exp_ecnt++;
            end
            ecs = (sel >= 0 && k <= a) ? N'(1 << sel) : '0;
            n_total++;
            if (s_cs_o !== ecs)
                $display("FAIL %s cs k=%0d got %h want %h", tag, k, s_cs_o, ecs);
            else n_pass++;
            n_total++;
            if (m_ack_o !== (k == rk && ok))
                $display("FAIL %s ack k=%0d got %b want %b", tag, k, m_ack_o, k == rk && ok);
            else n_pass++;
            n_total++;
            if (m_err_o !== (k == rk && !ok))
                $display("FAIL %s err k=%0d got %b want %b", tag, k, m_err_o, k == rk && !ok);
            else n_pass++;
            n_total++;
            if (busy_o !== (k <= rk))
                $display("FAIL %s busy k=%0d got %b want %b", tag, k, busy_o, k <= rk);
            else n_pass++;
            n_total++;
            if (m_dat_o !== exp_mdat)
                $display("FAIL %s mdat k=%0d got %h want %h", tag, k, m_dat_o, exp_mdat);
            else n_pass++;
            if (k <= a) begin
                n_total++;
                if (s_adr_o !== adr || s_we_o !== we || s_dat_o !== dat)
                    $display("FAIL %s sbus k=%0d got %h/%b/%h want %h/%b/%h",
                             tag, k, s_adr_o, s_we_o, s_dat_o, adr, we, dat);
                else n_pass++;
            end
            if (k == rk + 1) begin
                n_total++;
                if (err_cnt_o !== 8'(exp_ecnt))
                    $display("FAIL %s err_cnt got %0d want %0d", tag, err_cnt_o, exp_ecnt);
                else n_pass++;
                n_total++;
                if (err_adr_o !== exp_eadr)
                    $display("FAIL %s err_adr got %h want %h", tag, err_adr_o, exp_eadr);
                else n_pass++;
            end
            if (k == rk) m_stb_i = 1'b0;
            if (k <= a)
                s_ack_i = ~ecs | ((k == w + 1) ? ecs : '0);
            else
                s_ack_i = N'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({s_cs_o, s_we_o, s_adr_o, s_dat_o, m_dat_o, m_ack_o,
             m_err_o, err_adr_o, err_cnt_o, busy_o} !== '0)
            $display("FAIL reset outputs got cs=%h adr=%h cnt=%0d busy=%b want all 0",
                     s_cs_o, s_adr_o, err_cnt_o, busy_o);
        else n_pass++;
        rst_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy_o !== 1'b0 || s_cs_o !== '0)
            $display("FAIL reset_idle got busy=%b cs=%h want 0/0", busy_o, s_cs_o);
        else n_pass++;
    endtask

    task automatic test_read_hit();
        access(32'h2000_0004, 1'b0, 32'h0, 0, "read_hit");
        n_total++;
        if (m_dat_o !== slv_dat[2])
            $display("FAIL read_hit data got %h want %h", m_dat_o, slv_dat[2]);
        else n_pass++;
    endtask

    task automatic test_unmapped_write();
        access(32'hF000_0010, 1'b1, 32'h0000_1234, 0, "unmapped");
        n_total++;
        if (err_adr_o !== 32'hF000_0010 || err_cnt_o !== 8'd1)
            $display("FAIL unmapped log got %h/%0d want f0000010/1", err_adr_o, err_cnt_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        access(32'h6000_0020, 1'b0, 32'h0, 1000, "timeout");
        n_total++;
        if (err_cnt_o !== 8'd2)
            $display("FAIL timeout cnt got %0d want 2", err_cnt_o);
        else n_pass++;
    endtask

    task automatic test_ack_at_expiry();
        access(32'h7000_0100, 1'b0, 32'h0, TO - 1, "ack_expiry");
        n_total++;
        if (err_cnt_o !== 8'd2 || m_dat_o !== slv_dat[7])
            $display("FAIL ack_expiry got cnt=%0d dat=%h want 2/%h",
                     err_cnt_o, m_dat_o, slv_dat[7]);
        else n_pass++;
    endtask

    task automatic test_overlap();
        access(32'h1000_0040, 1'b0, 32'h0, 1, "overlap");
        n_total++;
        if (m_dat_o !== slv_dat[1])
            $display("FAIL overlap data got %h want %h", m_dat_o, slv_dat[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        load_slv_data();
        m_stb_i = 1'b1; m_we_i = 1'b0;
        m_adr_i = 32'h0000_0100; m_dat_i = '0;
        s_ack_i = '0;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (s_cs_o !== 8'h01)
            $display("FAIL b2b cs1 got %h want 01", s_cs_o);
        else n_pass++;
        s_ack_i = 8'h01;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (m_ack_o !== 1'b1 || m_dat_o !== slv_dat[0])
            $display("FAIL b2b ack1 got %b/%h want 1/%h", m_ack_o, m_dat_o, slv_dat[0]);
        else n_pass++;
        m_adr_i = 32'h4000_0008;
        s_ack_i = '0;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (busy_o !== 1'b0 || s_cs_o !== '0 || m_ack_o !== 1'b0)
            $display("FAIL b2b gap got busy=%b cs=%h ack=%b want 0/00/0",
                     busy_o, s_cs_o, m_ack_o);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (s_cs_o !== 8'h10 || s_adr_o !== 32'h4000_0008)
            $display("FAIL b2b cs2 got %h/%h want 10/40000008", s_cs_o, s_adr_o);
        else n_pass++;
        s_ack_i = 8'h10;
        @(posedge clk); @(negedge clk);
        m_stb_i = 1'b0;
        s_ack_i = '0;
        exp_mdat = slv_dat[4];
        n_total++;
        if (m_ack_o !== 1'b1 || m_dat_o !== exp_mdat)
            $display("FAIL b2b ack2 got %b/%h want 1/%h", m_ack_o, m_dat_o, exp_mdat);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (busy_o !== 1'b0 || m_ack_o !== 1'b0)
            $display("FAIL b2b end got busy=%b ack=%b want 0/0", busy_o, m_ack_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] adr;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                adr = 32'h5000_0000 | ($urandom & 32'h0001_FFFF);
            else
                adr = (32'($urandom_range(0, 15)) << 28) | ($urandom & 32'h0FFF_FFFF);
            access(adr, 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 6), "random");
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            access(32'h8000_0000 | ($urandom & 32'h7FFF_FFFF), 1'b1,
                   $urandom, 0, "saturate");
        end
        n_total++;
        if (err_cnt_o !== 8'd255)
            $display("FAIL saturate cnt got %0d want 255", err_cnt_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        load_slv_data();
        m_stb_i = 1'b1; m_we_i = 1'b1;
        m_adr_i = 32'h6000_0010; m_dat_i = 32'hA5A5_5A5A;
        s_ack_i = '0;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (s_cs_o !== 8'h40)
            $display("FAIL rst_mid cs got %h want 40", s_cs_o);
        else n_pass++;
        #1 rst_i = 1'b0;
        #1;
        n_total++;
        if ({s_cs_o, s_we_o, s_adr_o, s_dat_o, m_dat_o, m_ack_o,
             m_err_o, err_adr_o, err_cnt_o, busy_o} !== '0)
            $display("FAIL rst_mid outputs got cs=%h adr=%h cnt=%0d busy=%b want all 0",
                     s_cs_o, s_adr_o, err_cnt_o, busy_o);
        else n_pass++;
        m_stb_i = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b1;
        exp_mdat = '0; exp_eadr = '0; exp_ecnt = 0;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL rst_mid resp got ack=%b err=%b busy=%b want 0/0/0",
                     m_ack_o, m_err_o, busy_o);
        else n_pass++;
        access(32'h0000_0800, 1'b0, 32'h0, 2, "after_reset");
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        exp_mdat = '0; exp_eadr = '0; exp_ecnt = 0;
        m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0;
        s_dat_i = '0; s_ack_i = '0;
        test_reset();
        test_read_hit();
        test_unmapped_write();
        test_timeout();
        test_ack_at_expiry();
        test_overlap();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
